sw_arb: RTL and testbench

SW_ARB -- requirements
Module: sw_arb

---
 rtl/sw_arb.sv | 183 ++++++++++++++++++
 tb/tb_sw_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_arb.sv
// Purpose : 5x5 router switch allocator; per-output round-robin arbitration plus output flit register.
// Latency : 1 cycle, request (comb in_ready pop) to registered valid_out/data_out/grant_src.
// Backpr. : an output holds its flit while valid_out=1 and out_ready=0; losing or blocked inputs see in_ready=0 and must hold.
//
// Ports
//   rc_clk, rst_n        clock, async active-low reset
//   dir_in   [4*NPORT]   one-hot route direction per input (0000 = local, 1111 = idle)
//   valid_in [NPORT]     flit valid per input
//   data_in  [DW*NPORT]  flit per input
//   out_ready[NPORT]     downstream ready per output
//   in_ready [NPORT]     combinational pop to the winning inputs
//   data_out/valid_out   registered flit per output
//   grant_src[3*NPORT]   registered index of the input that supplied each output flit
//   err_dir              sticky flag for an illegal direction code on a valid input
module sw_arb #(
    parameter int DATASIZE = 40,
    parameter int NPORT    = 5
) (
    input  logic                      rc_clk,
    input  logic                      rst_n,
    input  logic [4*NPORT-1:0]        dir_in,
    input  logic [NPORT-1:0]          valid_in,
    input  logic [DATASIZE*NPORT-1:0] data_in,
    input  logic [NPORT-1:0]          out_ready,
    output logic [NPORT-1:0]          in_ready,
    output logic [DATASIZE*NPORT-1:0] data_out,
    output logic [NPORT-1:0]          valid_out,
    output logic [3*NPORT-1:0]        grant_src,
    output logic                      err_dir
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATASIZE*NPORT-1:0] data_out_q,  data_out_d;
    logic [NPORT-1:0]          valid_out_q, valid_out_d;
    logic [3*NPORT-1:0]        grant_src_q, grant_src_d;
    logic [2:0]                ptr_q [NPORT];
    logic [2:0]                ptr_d [NPORT];
    logic                      err_dir_q,   err_dir_d;

    // ------------------------------------------------------------------
    // Combinational intermediates
    // ------------------------------------------------------------------
    logic [NPORT-1:0] dec_vld;          // input carries a legal request
    logic [2:0]       dec_out [NPORT];  // requested output index
    logic [NPORT-1:0] dec_ill;          // illegal code on a valid input
    logic [NPORT-1:0] req     [NPORT];  // req[o][i]
    logic [NPORT-1:0] gnt     [NPORT];  // one-hot winner per output
    logic [NPORT-1:0] gnt_vld;
    logic [2:0]       gnt_idx [NPORT];
    logic [NPORT-1:0] out_free;
    logic [NPORT-1:0] in_ready_c;

    // Rotating search index: (base + off) mod NPORT, base/off both < NPORT.
    function automatic logic [2:0] rr_idx(input logic [2:0] base, input logic [2:0] off);
        logic [3:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 4'(NPORT)) begin
            s = s - 4'(NPORT);
        end
        return s[2:0];
    endfunction

    // ------------------------------------------------------------------
    // Direction decode. 1111 is the idle code and is neither a request
    // nor an error; every other non-one-hot code is flagged.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            dec_vld[i] = 1'b0;
            dec_out[i] = 3'd0;
            dec_ill[i] = 1'b0;
            unique case (dir_in[4*i +: 4])
                4'b0001: begin dec_vld[i] = valid_in[i]; dec_out[i] = 3'd0; end
                4'b0010: begin dec_vld[i] = valid_in[i]; dec_out[i] = 3'd1; end
                4'b0100: begin dec_vld[i] = valid_in[i]; dec_out[i] = 3'd2; end
                4'b1000: begin dec_vld[i] = valid_in[i]; dec_out[i] = 3'd3; end
                4'b0000: begin dec_vld[i] = valid_in[i]; dec_out[i] = 3'd4; end
                4'b1111: begin dec_vld[i] = 1'b0; end
                default: begin dec_ill[i] = valid_in[i]; end
            endcase
        end
    end

    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                req[o][i] = dec_vld[i] && (dec_out[i] == 3'(o));
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-output round-robin arbitration. Search starts at ptr and the
    // first requester found wins; a busy output grants nobody.
    // ------------------------------------------------------------------
    always_comb begin
        for (int o = 0; o < NPORT; o++) begin
            gnt[o]      = '0;
            gnt_vld[o]  = 1'b0;
            gnt_idx[o]  = 3'd0;
            out_free[o] = !valid_out_q[o] || out_ready[o];
            if (out_free[o]) begin
                for (int k = 0; k < NPORT; k++) begin
                    if (!gnt_vld[o] && req[o][rr_idx(ptr_q[o], 3'(k))]) begin
                        gnt_vld[o]                      = 1'b1;
                        gnt_idx[o]                      = rr_idx(ptr_q[o], 3'(k));
                        gnt[o][rr_idx(ptr_q[o], 3'(k))] = 1'b1;
                    end
                end
            end
        end
    end

    // Each input requests one output at most, so OR-ing the grant
    // vectors can never pop an input twice.
    always_comb begin
        in_ready_c = '0;
        for (int o = 0; o < NPORT; o++) begin
            in_ready_c = in_ready_c | gnt[o];
        end
    end

    // No pop may escape while the flops are held in reset.
    assign in_ready = rst_n ? in_ready_c : '0;

    // ------------------------------------------------------------------
    // Next-state: load winner, drain to idle, or hold when blocked.
    // A consume and a new grant in the same cycle simply overwrite.
    // ------------------------------------------------------------------
    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        grant_src_d = grant_src_q;
        for (int o = 0; o < NPORT; o++) begin
            ptr_d[o] = ptr_q[o];
        end
        for (int o = 0; o < NPORT; o++) begin
            if (out_free[o]) begin
                if (gnt_vld[o]) begin
                    valid_out_d[o]         = 1'b1;
                    grant_src_d[3*o +: 3]  = gnt_idx[o];
                    ptr_d[o]               = rr_idx(gnt_idx[o], 3'd1);
                    for (int i = 0; i < NPORT; i++) begin
                        if (gnt[o][i]) begin
                            data_out_d[DATASIZE*o +: DATASIZE] = data_in[DATASIZE*i +: DATASIZE];
                        end
                    end
                end else begin
                    valid_out_d[o] = 1'b0;
                end
            end
        end
        err_dir_d = err_dir_q || (|dec_ill);
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q  <= '0;
            valid_out_q <= '0;
            grant_src_q <= '0;
            err_dir_q   <= 1'b0;
            for (int o = 0; o < NPORT; o++) begin
                ptr_q[o] <= 3'd0;
            end
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            grant_src_q <= grant_src_d;
            err_dir_q   <= err_dir_d;
            for (int o = 0; o < NPORT; o++) begin
                ptr_q[o] <= ptr_d[o];
            end
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign grant_src = grant_src_q;
    assign err_dir   = err_dir_q;

endmodule

// File: tb/tb_sw_arb.sv
// Purpose : directed self-checking bench for sw_arb.
// Latency : inputs driven 1ns after the rising edge, comb outputs sampled before the next edge, registers 1ns after it.
// Backpr. : exercises output stall and release via out_ready.
module tb_sw_arb;
    localparam int DW = 40;
    localparam int NP = 5;

    logic              rc_clk;
    logic              rst_n;
    logic [4*NP-1:0]   dir_in;
    logic [NP-1:0]     valid_in;
    logic [DW*NP-1:0]  data_in;
    logic [NP-1:0]     out_ready;
    logic [NP-1:0]     in_ready;
    logic [DW*NP-1:0]  data_out;
    logic [NP-1:0]     valid_out;
    logic [3*NP-1:0]   grant_src;
    logic              err_dir;

    int checks   = 0;
    int failures = 0;

    sw_arb #(.DATASIZE(DW), .NPORT(NP)) dut (
        .rc_clk    (rc_clk),
        .rst_n     (rst_n),
        .dir_in    (dir_in),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant_src (grant_src),
        .err_dir   (err_dir)
    );

    initial rc_clk = 1'b0;
    always #5 rc_clk = ~rc_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i, input int n);
        return {8'hA0 + 8'(n), 24'h0, 8'(i)};
    endfunction

    task automatic drive(input int i, input logic [3:0] d, input logic v, input int n);
        dir_in[4*i +: 4]   = d;
        valid_in[i]        = v;
        data_in[DW*i +: DW] = pat(i, n);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NP; i++) drive(i, 4'b1111, 1'b0, 0);
    endtask

    task automatic tick();
        @(posedge rc_clk);
        #1;
    endtask

    int rr_exp[5] = '{0, 2, 4, 0, 2};

    initial begin
        rst_n     = 1'b0;
        out_ready = '1;
        dir_in    = '1;
        valid_in  = '0;
        data_in   = '0;
        idle_all();

        // Reset state, with a live request present
        drive(1, 4'b0010, 1'b1, 1);
        #2;
        chk("rst_in_ready",  64'(in_ready),  64'h0);
        chk("rst_valid_out", 64'(valid_out), 64'h0);
        chk("rst_grant_src", 64'(grant_src), 64'h0);
        chk("rst_err_dir",   64'(err_dir),   64'h0);
        tick();
        chk("rst_edge_valid", 64'(valid_out), 64'h0);
        rst_n = 1'b1;
        #1;

        // Basic single grant in1 -> out1
        chk("basic_in_ready", 64'(in_ready), 64'h02);
        tick();
        chk("basic_valid_out", 64'(valid_out), 64'h02);
        chk("basic_data1", 64'(data_out[DW*1 +: DW]), 64'(pat(1, 1)));
        chk("basic_src1",  64'(grant_src[3*1 +: 3]), 64'd1);
        idle_all();
        tick();
        chk("drain_valid_out", 64'(valid_out), 64'h0);
        chk("drain_hold_data", 64'(data_out[DW*1 +: DW]), 64'(pat(1, 1)));

        // Round-robin on local output: 0,2,4,0,2; valid stays 1 throughout
        drive(0, 4'b0000, 1'b1, 2);
        drive(2, 4'b0000, 1'b1, 2);
        drive(4, 4'b0000, 1'b1, 2);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_in_ready", 64'(in_ready), 64'(1 << rr_exp[k]));
            tick();
            chk("rr_src4",  64'(grant_src[3*4 +: 3]), 64'(rr_exp[k]));
            chk("rr_valid", 64'(valid_out), 64'h10);
            chk("rr_data4", 64'(data_out[DW*4 +: DW]), 64'(pat(rr_exp[k], 2)));
        end
        idle_all();
        tick();

        // Backpressure on out3
        drive(2, 4'b1000, 1'b1, 3);
        #1;
        chk("bp_first_in_ready", 64'(in_ready), 64'h04);
        tick();
        chk("bp_first_data3", 64'(data_out[DW*3 +: DW]), 64'(pat(2, 3)));
        out_ready[3] = 1'b0;
        drive(2, 4'b1000, 1'b1, 4);
        #1;
        chk("bp_stall_in_ready", 64'(in_ready), 64'h0);
        tick();
        tick();
        chk("bp_hold_data3", 64'(data_out[DW*3 +: DW]), 64'(pat(2, 3)));
        chk("bp_hold_valid", 64'(valid_out), 64'h08);
        out_ready[3] = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'h04);
        tick();
        chk("bp_release_data3", 64'(data_out[DW*3 +: DW]), 64'(pat(2, 4)));
        chk("bp_release_src3",  64'(grant_src[3*3 +: 3]), 64'd2);
        idle_all();
        tick();
        chk("bp_drain_valid", 64'(valid_out), 64'h0);

        // Parallel permutation: all five granted together
        drive(0, 4'b0010, 1'b1, 5);
        drive(1, 4'b0100, 1'b1, 5);
        drive(2, 4'b1000, 1'b1, 5);
        drive(3, 4'b0000, 1'b1, 5);
        drive(4, 4'b0001, 1'b1, 5);
        #1;
        chk("par_in_ready", 64'(in_ready), 64'h1F);
        tick();
        chk("par_valid_out", 64'(valid_out), 64'h1F);
        chk("par_grant_src", 64'(grant_src), 64'(15'b011_010_001_000_100));
        chk("par_data0", 64'(data_out[DW*0 +: DW]), 64'(pat(4, 5)));
        chk("par_data4", 64'(data_out[DW*4 +: DW]), 64'(pat(3, 5)));
        idle_all();
        tick();

        // Idle code with valid, illegal code without valid: no grant, no error
        drive(0, 4'b1111, 1'b1, 6);
        drive(3, 4'b0110, 1'b0, 6);
        #1;
        chk("noreq_in_ready", 64'(in_ready), 64'h0);
        tick();
        chk("noreq_valid_out", 64'(valid_out), 64'h0);
        chk("noreq_err_dir",   64'(err_dir),   64'h0);

        // Illegal code on a valid input
        idle_all();
        drive(3, 4'b0110, 1'b1, 7);
        #1;
        chk("ill_in_ready",   64'(in_ready), 64'h0);
        chk("ill_err_before", 64'(err_dir),  64'h0);
        tick();
        chk("ill_err_dir",   64'(err_dir),   64'h1);
        chk("ill_valid_out", 64'(valid_out), 64'h0);
        idle_all();
        tick();
        chk("ill_err_sticky", 64'(err_dir), 64'h1);

        // Reset mid-operation with a held flit on out1
        drive(1, 4'b0010, 1'b1, 8);
        tick();
        chk("mid_valid_pre", 64'(valid_out), 64'h02);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_err",       64'(err_dir),   64'h0);
        chk("mid_rst_valid",     64'(valid_out), 64'h0);
        chk("mid_rst_src",       64'(grant_src), 64'h0);
        chk("mid_rst_in_ready",  64'(in_ready),  64'h0);
        chk("mid_rst_data1",     64'(data_out[DW*1 +: DW]), 64'h0);
        idle_all();
        tick();
        rst_n = 1'b1;

        // Pointer reset: out4 ptr was 4 before reset; after reset in0 must win over in4
        drive(0, 4'b0000, 1'b1, 9);
        drive(4, 4'b0000, 1'b1, 9);
        #1;
        chk("ptr_rst_in_ready", 64'(in_ready), 64'h01);
        tick();
        chk("ptr_rst_src4", 64'(grant_src[3*4 +: 3]), 64'd0);
        #1;
        chk("ptr_next_in_ready", 64'(in_ready), 64'h10);
        tick();
        chk("ptr_next_src4", 64'(grant_src[3*4 +: 3]), 64'd4);
        idle_all();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
